// File: rtl/add_out_pkg.sv
// Shared types, defaults and the one-bit full adder for the bit-serial add_out_driver.
package add_out_pkg;

   localparam int ADD_OUT_WIDTH = 4;
   localparam int ADD_OUT_HOLD  = 2;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ADD   = 2'd1;
   localparam logic [1:0] ST_DRIVE = 2'd2;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      ADD   = ST_ADD,
      DRIVE = ST_DRIVE
   } add_out_state_t;

   // Returns {carry_out, sum_bit}.
   function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
      return {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
   endfunction

endpackage

// File: rtl/add_out_serial_core.sv
// Bit-serial adder datapath: operand shift registers, carry, bit counter and full adder.
// done/sum_bits/carry present the final result combinationally during the last bit-cycle.
module add_out_serial_core
   import add_out_pkg::*;
#(
   parameter int WIDTH = ADD_OUT_WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             done,
   output logic [WIDTH-1:0] sum_bits,
   output logic             carry
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d, s_shift;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             c_q, c_d, busy_q, busy_d;
   logic             fa_s, fa_c;

   assign {fa_c, fa_s} = full_add(a_q[0], b_q[0], c_q);

   // New bit enters at the MSB so that bit 0 lands at the LSB after WIDTH shifts.
   generate
      if (WIDTH == 1) begin : g_w1
         assign s_shift = fa_s;
      end else begin : g_wn
         assign s_shift = {fa_s, s_q[WIDTH-1:1]};
      end
   endgenerate

   assign sum_bits = s_shift;
   assign carry    = fa_c;

   always_comb begin
      a_d    = a_q;
      b_d    = b_q;
      s_d    = s_q;
      c_d    = c_q;
      cnt_d  = cnt_q;
      busy_d = busy_q;
      done   = 1'b0;
      if (start) begin
         a_d    = a;
         b_d    = b;
         c_d    = cin;
         s_d    = '0;
         cnt_d  = '0;
         busy_d = 1'b1;
      end else if (busy_q) begin
         a_d   = a_q >> 1;
         b_d   = b_q >> 1;
         c_d   = fa_c;
         s_d   = s_shift;
         cnt_d = cnt_q + CW'(1);
         if (cnt_q == CW'(WIDTH - 1)) begin
            done   = 1'b1;
            busy_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         a_q    <= '0;
         b_q    <= '0;
         s_q    <= '0;
         c_q    <= 1'b0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else begin
         a_q    <= a_d;
         b_q    <= b_d;
         s_q    <= s_d;
         c_q    <= c_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
      end
   end

endmodule

// File: rtl/add_out_driver.sv
// Bit-serial adder driving the out_intf cout/sum bus for HOLD_CYCLES per result.
// Define ADD_OUT_DRIVER_TRISTATE_EN to float sum/cout whenever out_valid is low.
module add_out_driver
   import add_out_pkg::*;
#(
   parameter int WIDTH       = ADD_OUT_WIDTH,
   parameter int HOLD_CYCLES = ADD_OUT_HOLD
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             cout,
   output logic [WIDTH-1:0] sum,
   output logic             out_valid
);

   localparam int HW = $clog2(HOLD_CYCLES + 1);

   add_out_state_t   state_q, state_d;
   logic [WIDTH-1:0] sum_q, sum_d, core_sum;
   logic             cout_q, cout_d, out_valid_q, out_valid_d;
   logic [HW-1:0]    hold_q, hold_d;
   logic             start, core_done, core_carry;

   assign in_ready = (state_q == IDLE) && !reset;
   assign start    = in_valid && in_ready;

   add_out_serial_core #(.WIDTH(WIDTH)) u_core (
      .clock    (clock),
      .reset    (reset),
      .start    (start),
      .a        (a),
      .b        (b),
      .cin      (cin),
      .done     (core_done),
      .sum_bits (core_sum),
      .carry    (core_carry)
   );

   always_comb begin
      state_d     = state_q;
      sum_d       = sum_q;
      cout_d      = cout_q;
      out_valid_d = out_valid_q;
      hold_d      = hold_q;
      case (state_q)
         IDLE: begin
            if (start) state_d = ADD;
         end
         ADD: begin
            if (core_done) begin
               sum_d       = core_sum;
               cout_d      = core_carry;
               hold_d      = HW'(HOLD_CYCLES);
               out_valid_d = 1'b1;
               state_d     = DRIVE;
            end
         end
         DRIVE: begin
            hold_d = hold_q - HW'(1);
            if (hold_q == HW'(1)) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         sum_q       <= '0;
         cout_q      <= 1'b0;
         out_valid_q <= 1'b0;
         hold_q      <= '0;
      end else begin
         state_q     <= state_d;
         sum_q       <= sum_d;
         cout_q      <= cout_d;
         out_valid_q <= out_valid_d;
         hold_q      <= hold_d;
      end
   end

   assign out_valid = out_valid_q;

`ifdef ADD_OUT_DRIVER_TRISTATE_EN
   // Shared bus: only drive while presenting a result, and never during reset.
   assign sum  = (out_valid_q && !reset) ? sum_q : {WIDTH{1'bz}};
   assign cout = (out_valid_q && !reset) ? cout_q : 1'bz;
`else
   assign sum  = sum_q;
   assign cout = cout_q;
`endif

endmodule
